// File: rtl/msx_bus_pkg.sv
// Shared definitions for the MSX cartridge slot responder.
//   msx_state_t     : responder state machine encoding
//   MAP_BANKx_BASE  : ASCII8 mapper register windows (2 KB each, 6000h-7FFFh)
//   PAGE_BASE       : first address of the banked read window (4000h-BFFFh)
//   READ_DEFAULT    : byte returned on reset and on a timed-out memory fetch
package msx_bus_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_FETCH = 2'd1,
        RD_HOLD  = 2'd2,
        WR_HOLD  = 2'd3
    } msx_state_t;

    localparam logic [15:0] MAP_BANK0_BASE = 16'h6000;
    localparam logic [15:0] MAP_BANK1_BASE = 16'h6800;
    localparam logic [15:0] MAP_BANK2_BASE = 16'h7000;
    localparam logic [15:0] MAP_BANK3_BASE = 16'h7800;
    localparam logic [15:0] MAP_WIN_LAST   = 16'h7FFF;
    localparam logic [15:0] PAGE_BASE      = 16'h4000;
    localparam logic [7:0]  READ_DEFAULT   = 8'hFF;

    // Only the top two address bits decide whether a read is ours.
    function automatic logic in_read_window(input logic [1:0] a_top);
        return (a_top == 2'b01) || (a_top == 2'b10);
    endfunction

    // 8 KB page index inside 4000h-BFFFh: 4000h->0, 6000h->1, 8000h->2, A000h->3.
    function automatic logic [1:0] page_of(input logic [15:0] a);
        return 2'((a - PAGE_BASE) >> 13);
    endfunction

    function automatic logic map_hit(input logic [15:0] a);
        return (a >= MAP_BANK0_BASE) && (a <= MAP_WIN_LAST);
    endfunction

    function automatic logic [1:0] map_index(input logic [15:0] a);
        if (a >= MAP_BANK3_BASE)      return 2'd3;
        else if (a >= MAP_BANK2_BASE) return 2'd2;
        else if (a >= MAP_BANK1_BASE) return 2'd1;
        else                          return 2'd0;
    endfunction

endpackage

// File: rtl/msx_strobe_sync.sv
// Multi-bit flip-flop synchroniser for the asynchronous Z80 bus strobes.
// All stages reset to 1 because the strobes are active-low and idle high.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous strobe inputs
//   q     : synchronised strobes, STAGES clocks behind d
module msx_strobe_sync #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '1;
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/msx_slot_responder.sv
// Cartridge-side MSX slot responder with an ASCII8 mapper. Reads in
// 4000h-BFFFh are fetched from a 2 MB external memory while the Z80 is held
// with WAIT; writes to 6000h-7FFFh load the four 8 KB bank registers.
//   clk, rst_n          : system clock (>= 8x MSX clock), async active-low reset
//   addr, data_in       : MSX address bus and write data
//   data_out, data_oe   : read data and its bus-drive enable
//   sltsl,mreq,iorq,rd,wr : active-low slot/Z80 strobes (iorq is ignored)
//   wait_n, busdir      : active-low WAIT request; BUSDIR (always 1)
//   mem_*               : external memory read port (req held until ack)
//   bank0..bank3        : current mapper registers
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for a qualified read or write
// RD_FETCH | memory fetch outstanding, Z80 held with WAIT
// RD_HOLD  | data driven on the bus until RD or SLTSL rises
// WR_HOLD  | mapper write done, waiting for WR to rise
module msx_slot_responder
    import msx_bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64,
    parameter int BANK_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    output logic                  data_oe,
    input  logic                  sltsl,
    input  logic                  mreq,
    input  logic                  iorq,
    input  logic                  rd,
    input  logic                  wr,
    output logic                  wait_n,
    output logic                  busdir,
    output logic [BANK_BITS+12:0] mem_addr,
    output logic                  mem_req,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata,
    output logic [BANK_BITS-1:0]  bank0,
    output logic [BANK_BITS-1:0]  bank1,
    output logic [BANK_BITS-1:0]  bank2,
    output logic [BANK_BITS-1:0]  bank3
);

    localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [3:0] strobe_s;
    logic       s_sltsl, s_mreq, s_rd, s_wr;
    logic       qual_rd, qual_wr, rd_gone, fetch_done;

    msx_state_t                    state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [3:0][BANK_BITS-1:0]     bank_q, bank_d;
    logic [7:0]                    data_out_d;
    logic                          data_oe_d, wait_n_d, mem_req_d;
    logic [BANK_BITS+12:0]         mem_addr_d;

    // IORQ cycles never qualify; the strobe is deliberately left unused.
    logic unused_ok;
    assign unused_ok = ^{iorq, data_in};

    msx_strobe_sync #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_strobe_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({sltsl, mreq, rd, wr}),
        .q     (strobe_s)
    );

    assign {s_sltsl, s_mreq, s_rd, s_wr} = strobe_s;

    // addr/data_in are stable by the time the synchronised strobe arrives,
    // so they are used directly on the detecting edge.
    assign qual_rd    = !s_sltsl && !s_mreq && !s_rd && in_read_window(addr[15:14]);
    assign qual_wr    = !s_sltsl && !s_mreq && !s_wr;
    assign rd_gone    = s_rd || s_sltsl;
    assign fetch_done = mem_ack || (cnt_q == CNT_LAST);

    assign busdir = 1'b1;
    assign bank0  = bank_q[0];
    assign bank1  = bank_q[1];
    assign bank2  = bank_q[2];
    assign bank3  = bank_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bank_q   <= '0;
            data_out <= READ_DEFAULT;
            data_oe  <= 1'b0;
            wait_n   <= 1'b1;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bank_q   <= bank_d;
            data_out <= data_out_d;
            data_oe  <= data_oe_d;
            wait_n   <= wait_n_d;
            mem_req  <= mem_req_d;
            mem_addr <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bank_d     = bank_q;
        data_out_d = data_out;
        data_oe_d  = data_oe;
        wait_n_d   = wait_n;
        mem_req_d  = mem_req;
        mem_addr_d = mem_addr;

        case (state_q)
            IDLE: begin
                if (qual_rd) begin
                    state_d    = RD_FETCH;
                    wait_n_d   = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {bank_q[page_of(addr)], addr[12:0]};
                    cnt_d      = '0;
                end else if (qual_wr) begin
                    state_d = WR_HOLD;
                    if (map_hit(addr)) begin
                        bank_d[map_index(addr)] = data_in[BANK_BITS-1:0];
                    end
                end
            end

            RD_FETCH: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (rd_gone) begin
                    wait_n_d = 1'b1;
                end
                if (fetch_done) begin
                    mem_req_d = 1'b0;
                    // wait_n already high here means the read was withdrawn
                    // earlier in this fetch; the result is then discarded.
                    if (rd_gone || wait_n) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = RD_HOLD;
                        data_out_d = mem_ack ? mem_rdata : READ_DEFAULT;
                        data_oe_d  = 1'b1;
                        wait_n_d   = 1'b1;
                    end
                end
            end

            RD_HOLD: begin
                if (rd_gone) begin
                    data_oe_d = 1'b0;
                    state_d   = IDLE;
                end
            end

            WR_HOLD: begin
                if (s_wr) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_msx_slot_responder.sv
module tb_msx_slot_responder;

    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 64;
    localparam int BANK_BITS   = 8;
    localparam int MA_W        = BANK_BITS + 13;

    logic                 clk;
    logic                 rst_n;
    logic [15:0]          addr;
    logic [7:0]           data_in;
    logic [7:0]           data_out;
    logic                 data_oe;
    logic                 sltsl, mreq, iorq, rd, wr;
    logic                 wait_n;
    logic                 busdir;
    logic [MA_W-1:0]      mem_addr;
    logic                 mem_req;
    logic                 mem_ack;
    logic [7:0]           mem_rdata;
    logic [BANK_BITS-1:0] bank0, bank1, bank2, bank3;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model controls
    bit         mem_enable = 1'b1;
    int         ack_delay  = 3;
    logic [7:0] mem_data   = 8'h5A;
    int         ack_cnt    = 0;

    msx_slot_responder #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT),
        .BANK_BITS   (BANK_BITS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .sltsl     (sltsl),
        .mreq      (mreq),
        .iorq      (iorq),
        .rd        (rd),
        .wr        (wr),
        .wait_n    (wait_n),
        .busdir    (busdir),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bank0     (bank0),
        .bank1     (bank1),
        .bank2     (bank2),
        .bank3     (bank3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: acks ack_delay cycles after it sees mem_req, unless disabled.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (mem_req && mem_enable) begin
                if (ack_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_data;
                    ack_cnt   = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_release();
        sltsl = 1'b1; mreq = 1'b1; iorq = 1'b1; rd = 1'b1; wr = 1'b1;
    endtask

    task automatic do_read(input logic [15:0] a, output int fall_n,
                           output logic [MA_W-1:0] maddr, output int low_n,
                           output logic ack_before, output logic oe,
                           output logic [7:0] dout, output logic req,
                           output logic oe_dropped);
        logic prev_ack;
        fall_n = 0; low_n = 0; maddr = '0; ack_before = 1'b0; oe = 1'b0;
        dout = 8'h00; req = 1'b1; oe_dropped = 1'b0; prev_ack = 1'b0;
        @(negedge clk);
        addr = a; sltsl = 1'b0; mreq = 1'b0; rd = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (!wait_n) begin
                fall_n = i;
                break;
            end
        end
        if (fall_n != 0) begin
            maddr    = mem_addr;
            low_n    = 1;
            prev_ack = mem_ack;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (wait_n) break;
                low_n++;
                prev_ack = mem_ack;
            end
            ack_before = prev_ack;
            oe   = data_oe;
            dout = data_out;
            req  = mem_req;
            repeat (2) @(negedge clk);
            oe = oe && data_oe;
        end
        @(negedge clk);
        bus_release();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!data_oe) begin
                oe_dropped = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            output logic activity);
        activity = 1'b0;
        @(negedge clk);
        addr = a; data_in = d; sltsl = 1'b0; mreq = 1'b0; wr = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (!wait_n || data_oe || mem_req) activity = 1'b1;
        end
        bus_release();
        repeat (4) begin
            @(negedge clk);
            if (!wait_n || data_oe || mem_req) activity = 1'b1;
        end
    endtask

    task automatic observe(input int n, output logic saw);
        saw = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (mem_req || !wait_n || data_oe) saw = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        addr = 16'h0000; data_in = 8'h00;
        bus_release();
        #23;
        n_checks++; if (bank0 !== 8'h00)   begin n_fail++; $display("FAIL reset_bank0: got %h want 00", bank0); end
        n_checks++; if (bank1 !== 8'h00)   begin n_fail++; $display("FAIL reset_bank1: got %h want 00", bank1); end
        n_checks++; if (bank2 !== 8'h00)   begin n_fail++; $display("FAIL reset_bank2: got %h want 00", bank2); end
        n_checks++; if (bank3 !== 8'h00)   begin n_fail++; $display("FAIL reset_bank3: got %h want 00", bank3); end
        n_checks++; if (data_oe !== 1'b0)  begin n_fail++; $display("FAIL reset_data_oe: got %b want 0", data_oe); end
        n_checks++; if (data_out !== 8'hFF) begin n_fail++; $display("FAIL reset_data_out: got %h want ff", data_out); end
        n_checks++; if (wait_n !== 1'b1)   begin n_fail++; $display("FAIL reset_wait: got %b want 1", wait_n); end
        n_checks++; if (busdir !== 1'b1)   begin n_fail++; $display("FAIL reset_busdir: got %b want 1", busdir); end
        n_checks++; if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++; if (mem_addr !== 21'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_read_basic();
        int fall_n, low_n;
        logic [MA_W-1:0] maddr;
        logic ackb, oe, req, dropped;
        logic [7:0] dout;
        mem_enable = 1'b1; ack_delay = 3; mem_data = 8'h5A;
        do_read(16'h4123, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        n_checks++; if (fall_n !== SYNC_STAGES + 1) begin n_fail++; $display("FAIL rd_wait_latency: got %0d want %0d", fall_n, SYNC_STAGES + 1); end
        n_checks++; if (maddr !== 21'h000123) begin n_fail++; $display("FAIL rd_mem_addr: got %h want 000123", maddr); end
        n_checks++; if (ackb !== 1'b1)  begin n_fail++; $display("FAIL rd_wait_after_ack: ack cycle before release %b want 1", ackb); end
        n_checks++; if (oe !== 1'b1)    begin n_fail++; $display("FAIL rd_data_oe: got %b want 1", oe); end
        n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL rd_data_out: got %h want 5a", dout); end
        n_checks++; if (req !== 1'b0)   begin n_fail++; $display("FAIL rd_mem_req_drop: got %b want 0", req); end
        n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL rd_oe_release: got %b want 1", dropped); end
    endtask

    task automatic test_mapper();
        int fall_n, low_n;
        logic [MA_W-1:0] maddr;
        logic ackb, oe, req, dropped, act;
        logic [7:0] dout;
        do_write(16'h7000, 8'h07, act);
        n_checks++; if (act !== 1'b0)   begin n_fail++; $display("FAIL map_wr_activity: got %b want 0", act); end
        n_checks++; if (bank2 !== 8'h07) begin n_fail++; $display("FAIL map_bank2: got %h want 07", bank2); end
        n_checks++; if (bank0 !== 8'h00) begin n_fail++; $display("FAIL map_bank0_untouched: got %h want 00", bank0); end
        do_read(16'h8001, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        n_checks++; if (maddr !== 21'h00E001) begin n_fail++; $display("FAIL map_rd_8001: got %h want 00e001", maddr); end
        do_read(16'hA001, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        n_checks++; if (maddr !== 21'h000001) begin n_fail++; $display("FAIL map_rd_a001: got %h want 000001", maddr); end
        do_write(16'h6800, 8'h12, act);
        do_write(16'h7800, 8'h99, act);
        do_write(16'h67FF, 8'h44, act);
        n_checks++; if (bank0 !== 8'h44) begin n_fail++; $display("FAIL map_bank0_67ff: got %h want 44", bank0); end
        n_checks++; if (bank1 !== 8'h12) begin n_fail++; $display("FAIL map_bank1: got %h want 12", bank1); end
        n_checks++; if (bank2 !== 8'h07) begin n_fail++; $display("FAIL map_bank2_kept: got %h want 07", bank2); end
        n_checks++; if (bank3 !== 8'h99) begin n_fail++; $display("FAIL map_bank3: got %h want 99", bank3); end
        do_read(16'h6005, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        n_checks++; if (maddr !== 21'h024005) begin n_fail++; $display("FAIL map_rd_6005: got %h want 024005", maddr); end
        do_read(16'hBFFF, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        n_checks++; if (maddr !== 21'h133FFF) begin n_fail++; $display("FAIL map_rd_bfff: got %h want 133fff", maddr); end
        do_read(16'h5FFF, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        n_checks++; if (maddr !== 21'h089FFF) begin n_fail++; $display("FAIL map_rd_5fff: got %h want 089fff", maddr); end
    endtask

    task automatic test_rom_writes();
        logic act_a, act_b;
        do_write(16'h5000, 8'h33, act_a);
        do_write(16'hC000, 8'h33, act_b);
        n_checks++; if ({bank0, bank1, bank2, bank3} !== 32'h44120799)
            begin n_fail++; $display("FAIL rom_wr_banks: got %h want 44120799", {bank0, bank1, bank2, bank3}); end
        n_checks++; if ((act_a | act_b) !== 1'b0)
            begin n_fail++; $display("FAIL rom_wr_activity: got %b want 0", act_a | act_b); end
    endtask

    task automatic test_timeout();
        int fall_n, low_n;
        logic [MA_W-1:0] maddr;
        logic ackb, oe, req, dropped;
        logic [7:0] dout;
        mem_enable = 1'b0;
        do_read(16'h4000, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        mem_enable = 1'b1;
        n_checks++; if (low_n !== TIMEOUT) begin n_fail++; $display("FAIL to_wait_cycles: got %0d want %0d", low_n, TIMEOUT); end
        n_checks++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL to_data_out: got %h want ff", dout); end
        n_checks++; if (oe !== 1'b1)    begin n_fail++; $display("FAIL to_data_oe: got %b want 1", oe); end
        n_checks++; if (req !== 1'b0)   begin n_fail++; $display("FAIL to_mem_req: got %b want 0", req); end
    endtask

    task automatic test_no_response();
        logic saw;
        @(negedge clk);
        addr = 16'h0100; sltsl = 1'b0; mreq = 1'b0; rd = 1'b0;
        observe(8, saw);
        bus_release();
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL nr_rd_0100: activity %b want 0", saw); end
        observe(3, saw);
        addr = 16'h4000; sltsl = 1'b1; mreq = 1'b0; rd = 1'b0;
        observe(8, saw);
        bus_release();
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL nr_rd_unselected: activity %b want 0", saw); end
        observe(3, saw);
        addr = 16'h4000; sltsl = 1'b0; iorq = 1'b0; rd = 1'b0;
        observe(8, saw);
        bus_release();
        n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL nr_iorq: activity %b want 0", saw); end
        observe(3, saw);
    endtask

    task automatic test_abort();
        logic saw_oe;
        bit   fell;
        ack_delay = 10;
        fell = 1'b0;
        @(negedge clk);
        addr = 16'h4200; sltsl = 1'b0; mreq = 1'b0; rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!wait_n) begin fell = 1'b1; break; end
        end
        n_checks++; if (fell !== 1'b1) begin n_fail++; $display("FAIL ab_wait_fall: got %b want 1", fell); end
        bus_release();
        repeat (4) @(negedge clk);
        n_checks++; if (wait_n !== 1'b1)  begin n_fail++; $display("FAIL ab_wait_release: got %b want 1", wait_n); end
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ab_mem_req_held: got %b want 1", mem_req); end
        saw_oe = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (data_oe) saw_oe = 1'b1;
        end
        n_checks++; if (saw_oe !== 1'b0)  begin n_fail++; $display("FAIL ab_no_data_oe: got %b want 0", saw_oe); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ab_mem_req_done: got %b want 0", mem_req); end
        ack_delay = 3;
    endtask

    task automatic test_reset_mid();
        int fall_n, low_n;
        logic [MA_W-1:0] maddr;
        logic ackb, oe, req, dropped;
        logic [7:0] dout;
        bit fell;
        mem_enable = 1'b0;
        fell = 1'b0;
        @(negedge clk);
        addr = 16'h4000; sltsl = 1'b0; mreq = 1'b0; rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!wait_n) begin fell = 1'b1; break; end
        end
        repeat (2) @(negedge clk);
        n_checks++; if ((fell && !wait_n && mem_req) !== 1'b1)
            begin n_fail++; $display("FAIL rm_in_fetch: wait %b req %b want 0 1", wait_n, mem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (wait_n !== 1'b1)   begin n_fail++; $display("FAIL rm_wait: got %b want 1", wait_n); end
        n_checks++; if (data_oe !== 1'b0)  begin n_fail++; $display("FAIL rm_data_oe: got %b want 0", data_oe); end
        n_checks++; if (mem_req !== 1'b0)  begin n_fail++; $display("FAIL rm_mem_req: got %b want 0", mem_req); end
        n_checks++; if ({bank0, bank1, bank2, bank3} !== 32'h0)
            begin n_fail++; $display("FAIL rm_banks: got %h want 00000000", {bank0, bank1, bank2, bank3}); end
        n_checks++; if (mem_addr !== 21'h0) begin n_fail++; $display("FAIL rm_mem_addr: got %h want 0", mem_addr); end
        bus_release();
        @(negedge clk);
        rst_n = 1'b1;
        mem_enable = 1'b1; mem_data = 8'hC3;
        repeat (2) @(negedge clk);
        do_read(16'h4010, fall_n, maddr, low_n, ackb, oe, dout, req, dropped);
        n_checks++; if (maddr !== 21'h000010) begin n_fail++; $display("FAIL rm_next_addr: got %h want 000010", maddr); end
        n_checks++; if (dout !== 8'hC3) begin n_fail++; $display("FAIL rm_next_data: got %h want c3", dout); end
        n_checks++; if (oe !== 1'b1)    begin n_fail++; $display("FAIL rm_next_oe: got %b want 1", oe); end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_mapper();
        test_rom_writes();
        test_timeout();
        test_no_response();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
